spike_rate_decoder: RTL and testbench

- Receiver end of the neuron spike interface: turns a 1-bit spike train (e.g. the izh `spike` output) back into numeric values.
- Two measurements: spike count over a programmable window (rate), and inter-spike interval (ISI) in clock cycles.
- Rate results leave through a valid/ready handshake; ISI results leave as single-cycle pulses.
- Sits between the neuron array and readout/learning logic.

---
 rtl/spike_rate_decoder.sv | 160 ++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder
// Receiver side of the neuron spike interface. It turns a 1-bit spike train
// into two measurements:
//   - rate: rising edges counted over a programmable window. Results leave
//     through a valid/ready handshake.
//   - ISI: inter-spike interval in clock cycles. Each result is reported as a
//     one-cycle pulse.
// A spike held high for several cycles counts once. Both counters saturate
// instead of wrapping.
module spike_rate_decoder #(
    parameter int CNT_W = 8,
    parameter int ISI_W = 12,
    parameter int WIN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_MAX = '1;
    localparam logic [ISI_W-1:0] ISI_ONE = ISI_W'(1);
    localparam logic [WIN_W:0]   WIN_ONE = (WIN_W + 1)'(1);

    state_t           state;
    state_t           state_next;
    logic             spike_q;
    logic             spike_edge;
    logic [WIN_W:0]   win_cnt;     // one extra bit so a length of 2^WIN_W fits
    logic [WIN_W:0]   win_load;
    logic             win_last;
    logic [CNT_W-1:0] spk_cnt;
    logic [CNT_W-1:0] spk_next;
    logic [ISI_W-1:0] isi_cnt;
    logic             seen_first;

    // A rising edge is the only event that counts, so a held-high spike is seen once.
    assign spike_edge = spike_in & ~spike_q;

    // A window_len of zero encodes the longest window, 2^WIN_W cycles.
    assign win_load = (window_len == '0) ? {1'b1, {WIN_W{1'b0}}} : {1'b0, window_len};
    assign win_last = (win_cnt == WIN_ONE);

    // Saturating spike count that includes the current cycle's edge.
    // On the last cycle of a window this value becomes the published result.
    assign spk_next = (spike_edge && (spk_cnt != CNT_MAX)) ? spk_cnt + 1'b1 : spk_cnt;

    // State register.
    // NOTE: reset here is synchronous and active-low. reset_n is sampled
    // like any other input, so it belongs inside the clocked branch and not
    // in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // enable alone moves the FSM between IDLE and RUN.
    // NOTE: state_next gets a default before the case statement. That way
    // every path assigns it and no latch can be inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable)  state_next = RUN;
            RUN:     if (!enable) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Spike history for edge detection. It tracks the input in every state.
    // NOTE: all clocked state uses non-blocking assignments. Every register
    // then sees the pre-edge values of the others, whatever order the
    // statements appear in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            spike_q <= 1'b0;
        end else begin
            spike_q <= spike_in;
        end
    end

    // Window counter, rate result with handshake, and ISI measurement.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_cnt    <= '0;
            spk_cnt    <= '0;
            isi_cnt    <= '0;
            seen_first <= 1'b0;
            rate_out   <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            isi_out    <= '0;
            isi_valid  <= 1'b0;
        end else begin
            isi_valid <= 1'b0;

            // A consumer may take a pending result in any state. A window
            // that ends in the same cycle re-raises out_valid below.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == IDLE) begin
                // IDLE clears the measurement state but keeps any pending result.
                win_cnt    <= enable ? win_load : '0;
                spk_cnt    <= '0;
                isi_cnt    <= '0;
                seen_first <= 1'b0;
                overrun    <= 1'b0;
            end else if (enable) begin
                if (win_last) begin
                    // Last cycle of the window: publish the count and start
                    // the next window with no dead cycle in between.
                    rate_out  <= spk_next;
                    out_valid <= 1'b1;
                    if (out_valid && !out_ready) begin
                        overrun <= 1'b1;
                    end
                    spk_cnt <= '0;
                    win_cnt <= win_load;
                end else begin
                    spk_cnt <= spk_next;
                    win_cnt <= win_cnt - 1'b1;
                end

                if (spike_edge) begin
                    // Restart the interval timer.
                    // The first edge after entering RUN has nothing to measure against.
                    isi_cnt    <= ISI_ONE;
                    seen_first <= 1'b1;
                    if (seen_first) begin
                        isi_out   <= isi_cnt;
                        isi_valid <= 1'b1;
                    end
                end else if (seen_first && (isi_cnt != ISI_MAX)) begin
                    isi_cnt <= isi_cnt + 1'b1;
                end
            end
            // RUN with enable low: the partial window is abandoned and IDLE
            // clears it on the next cycle.
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder.
// Directed scenarios are followed by a randomized phase. Two DUT instances
// share the stimulus: one with the default count width, one with a 4-bit
// count that exercises saturation. Expected values come from a
// timestamp-based reference model:
//   - window ends are absolute cycle numbers;
//   - a window's rate is the number of edge timestamps collected in it;
//   - an ISI is the difference between two edge timestamps.
module tb_spike_rate_decoder;

    localparam int ISI_MAX = 4095;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        spike_in;
    logic [7:0]  window_len;
    logic        out_ready;

    logic [7:0]  rate_out;
    logic        out_valid;
    logic        overrun;
    logic [11:0] isi_out;
    logic        isi_valid;

    logic [3:0]  rate4;
    logic        valid4;
    logic        overrun4;
    logic [11:0] isi4;
    logic        isi_valid4;

    spike_rate_decoder u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun),
        .isi_out    (isi_out),
        .isi_valid  (isi_valid)
    );

    spike_rate_decoder #(.CNT_W(4)) u_dut_c4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate4),
        .out_valid  (valid4),
        .out_ready  (out_ready),
        .overrun    (overrun4),
        .isi_out    (isi4),
        .isi_valid  (isi_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    bit m_run      = 1'b0;
    int m_win_end  = 0;
    int m_last     = -1;       // timestamp of the previous edge, -1 = none
    bit m_prev     = 1'b0;
    int m_edges[$];            // edge timestamps in the current window

    int e_rate      = 0;
    int e_rate4     = 0;
    int e_valid     = 0;
    int e_overrun   = 0;
    int e_isi       = 0;
    int e_isi_valid = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int win_n(input logic [7:0] w);
        return (w == 8'd0) ? 256 : int'(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Advance the model by one clock edge, using the inputs the DUT sees at that edge.
    task automatic model_step();
        bit edge_now;
        bit consumed;
        int next_isi_valid;
        edge_now = spike_in && !m_prev;
        if (!reset_n) begin
            m_run = 1'b0; m_last = -1; m_edges.delete();
            e_rate = 0; e_rate4 = 0; e_valid = 0; e_overrun = 0; e_isi = 0; e_isi_valid = 0;
        end else begin
            consumed       = (e_valid != 0) && out_ready;
            next_isi_valid = 0;
            if (!m_run) begin
                e_overrun = 0;
                m_last    = -1;
                m_edges.delete();
                if (consumed) e_valid = 0;
                if (enable) begin
                    m_run     = 1'b1;
                    m_win_end = cyc + win_n(window_len);
                end
            end else if (!enable) begin
                m_run = 1'b0;
                if (consumed) e_valid = 0;
            end else begin
                if (edge_now) begin
                    m_edges.push_back(cyc);
                    if (m_last >= 0) begin
                        e_isi          = imin(cyc - m_last, ISI_MAX);
                        next_isi_valid = 1;
                    end
                    m_last = cyc;
                end
                if (cyc == m_win_end) begin
                    if ((e_valid != 0) && !out_ready) e_overrun = 1;
                    e_rate    = imin(m_edges.size(), 255);
                    e_rate4   = imin(m_edges.size(), 15);
                    e_valid   = 1;
                    m_edges.delete();
                    m_win_end = cyc + win_n(window_len);
                end else if (consumed) begin
                    e_valid = 0;
                end
            end
            e_isi_valid = next_isi_valid;
        end
        m_prev = reset_n ? spike_in : 1'b0;
    endtask

    task automatic check_all();
        check("rate_out",   32'(rate_out),   e_rate);
        check("out_valid",  32'(out_valid),  e_valid);
        check("overrun",    32'(overrun),    e_overrun);
        check("isi_out",    32'(isi_out),    e_isi);
        check("isi_valid",  32'(isi_valid),  e_isi_valid);
        check("rate4",      32'(rate4),      e_rate4);
        check("valid4",     32'(valid4),     e_valid);
        check("overrun4",   32'(overrun4),   e_overrun);
        check("isi4",       32'(isi4),       e_isi);
        check("isi_valid4", 32'(isi_valid4), e_isi_valid);
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        spike_in   = 1'b0;
        window_len = 8'd10;
        out_ready  = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_rate",  32'(rate_out),  0);
        check("rst_valid", 32'(out_valid), 0);
        reset_n = 1'b1;
        tick();
        tick();

        // Basic rate: window of 10, spikes at E+2, E+5, E+8
        window_len = 8'd10;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            spike_in = (k == 2 || k == 5 || k == 8);
            tick();
            if (k == 10) begin
                check("s1_rate",  32'(rate_out),  3);
                check("s1_valid", 32'(out_valid), 1);
            end
            if (k == 11) check("s1_pulse_width", 32'(out_valid), 0);
            if (k == 20) begin
                check("s1_win2_rate",  32'(rate_out),  0);
                check("s1_win2_valid", 32'(out_valid), 1);
            end
        end
        enable = 1'b0;
        tick();
        tick();

        // Held spike, then a rising edge on the last cycle of the next window
        window_len = 8'd4;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            spike_in = ((k >= 2) && (k <= 4)) || (k == 8);
            tick();
            if (k == 4) check("s2_held_rate", 32'(rate_out), 1);
            if (k == 8) check("s2_last_edge_rate", 32'(rate_out), 1);
        end
        spike_in = 1'b0;
        enable   = 1'b0;
        tick();
        tick();

        // Handshake and overrun: 2 spikes, then 4 spikes, no consumer
        window_len = 8'd8;
        out_ready  = 1'b0;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            spike_in = (k == 2 || k == 5 || k == 10 || k == 12 || k == 14 || k == 16);
            tick();
            if (k == 8) begin
                check("s3_w1_rate",    32'(rate_out), 2);
                check("s3_w1_overrun", 32'(overrun),  0);
            end
            if (k == 16) begin
                check("s3_w2_rate",    32'(rate_out),  4);
                check("s3_w2_valid",   32'(out_valid), 1);
                check("s3_w2_overrun", 32'(overrun),   1);
            end
        end
        spike_in  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("s3_consumed", 32'(out_valid), 0);
        check("s3_sticky",   32'(overrun),   1);
        tick();
        tick();
        tick();
        check("s3_sticky_later", 32'(overrun), 1);
        enable = 1'b0;
        tick();
        check("s3_sticky_disable", 32'(overrun), 1);
        tick();
        check("s3_cleared_idle", 32'(overrun), 0);

        // ISI: edges at E+3, E+10, E+12, then a gap longer than the counter range
        window_len = 8'd0;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 4112; k++) begin
            spike_in = (k == 3 || k == 10 || k == 12 || k == 4112);
            tick();
            if (k == 3) check("s4_first_edge", 32'(isi_valid), 0);
            if (k == 10) begin
                check("s4_isi7_valid", 32'(isi_valid), 1);
                check("s4_isi7",       32'(isi_out),   7);
            end
            if (k == 11) check("s4_pulse_width", 32'(isi_valid), 0);
            if (k == 12) check("s4_isi2", 32'(isi_out), 2);
            if (k == 4112) begin
                check("s4_sat_valid", 32'(isi_valid), 1);
                check("s4_isi_sat",   32'(isi_out),   ISI_MAX);
            end
        end
        spike_in = 1'b0;
        enable   = 1'b0;
        tick();
        tick();

        // Saturation: toggle every cycle over a 256-cycle window
        window_len = 8'd0;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 256; k++) begin
            spike_in = (k % 2 == 1);
            tick();
        end
        check("s5_rate256",   32'(rate_out),  128);
        check("s5_rate4_sat", 32'(rate4),     15);
        check("s5_valid",     32'(out_valid), 1);
        spike_in = 1'b0;
        enable   = 1'b0;
        tick();
        tick();

        // Disable mid-window: no result, and ISI history is cleared
        window_len = 8'd10;
        enable     = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) begin
            spike_in = (k == 2 || k == 4);
            tick();
            if (k == 4) check("s6_isi2", 32'(isi_out), 2);
        end
        enable   = 1'b0;
        spike_in = 1'b1;
        tick();
        check("s6_no_result",  32'(out_valid), 0);
        check("s6_edge_ignored", 32'(isi_valid), 0);
        spike_in = 1'b0;
        tick();
        out_ready = 1'b0;
        enable    = 1'b1;
        tick();
        for (int k = 1; k <= 13; k++) begin
            spike_in = (k == 3 || k == 6);
            tick();
            if (k == 3) check("s6_first_after_reenable", 32'(isi_valid), 0);
            if (k == 6) check("s6_isi3", 32'(isi_out), 3);
            if (k == 10) check("s6_pending_rate", 32'(rate_out), 2);
        end

        // Reset with a pending result
        reset_n = 1'b0;
        tick();
        check("s6_rst_rate",    32'(rate_out),  0);
        check("s6_rst_valid",   32'(out_valid), 0);
        check("s6_rst_isi",     32'(isi_out),   0);
        check("s6_rst_overrun", 32'(overrun),   0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        tick();

        // Randomized phase against the reference model
        window_len = 8'd6;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            if ($urandom_range(0, 19) == 0)
                window_len = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            spike_in  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset_n   = ($urandom_range(0, 999) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
